// File: rtl/pic_irq_arbiter.sv
// rtl/pic_irq_arbiter.sv - 8259-compatible IRR/ISR priority arbiter and INTA vector sequencer
//
// Purpose: owns IRR and ISR, resolves priority among the eight IR lines with
// masking, fully nested blocking and rotation, drives INT to the CPU, walks
// the two-pulse INTA handshake and presents the 8086-mode vector byte.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ir_in[7:0]              request lines (already synchronous to clk)
//   ltim                    1 = level triggered, 0 = edge triggered
//   aeoi, rotate_aeoi       automatic EOI and rotate-on-AEOI controls
//   imr[7:0]                interrupt mask, 1 = masked
//   vector_base[4:0]        ICW2 T7..T3
//   inta_n                  interrupt acknowledge, active-low
//   eoi_valid               one-cycle OCW2 EOI strobe
//   eoi_specific            1 = specific EOI on eoi_level, 0 = non-specific
//   eoi_rotate              rotate priority to the cleared level
//   eoi_level[2:0]          target level for a specific EOI
//   int_out                 interrupt request to the CPU (registered)
//   vector_valid            vector_out is to be driven onto the bus
//   vector_out[7:0]         {vector_base, level}
//   irr[7:0], isr[7:0]      request and in-service registers

module pic_irq_arbiter #(
  parameter int         NUM_IR       = 8,
  parameter logic [2:0] RESET_LOWEST = 3'd7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IR-1:0] ir_in,
  input  logic              ltim,
  input  logic              aeoi,
  input  logic              rotate_aeoi,
  input  logic [NUM_IR-1:0] imr,
  input  logic [4:0]        vector_base,
  input  logic              inta_n,
  input  logic              eoi_valid,
  input  logic              eoi_specific,
  input  logic              eoi_rotate,
  input  logic [2:0]        eoi_level,
  output logic              int_out,
  output logic              vector_valid,
  output logic [7:0]        vector_out,
  output logic [NUM_IR-1:0] irr,
  output logic [NUM_IR-1:0] isr
);

  // ACK1 is split in two: waiting for the first INTA pulse to end, then
  // waiting for the second pulse to begin.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACK1    = 2'd1,
    S_ACK1_HI = 2'd2,
    S_ACK2    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_IR-1:0]   irr_q, irr_d;
  logic [NUM_IR-1:0]   isr_q, isr_d;
  logic [NUM_IR-1:0]   ir_prev_q, ir_prev_d;
  logic                inta_prev_q, inta_prev_d;
  logic [2:0]          lowest_q, lowest_d;
  logic [2:0]          winner_q, winner_d;
  logic                spurious_q, spurious_d;
  logic                int_out_q, int_out_d;
  logic                vector_valid_q, vector_valid_d;
  logic [7:0]          vector_out_q, vector_out_d;

  // Returns {found, level} of the highest-priority set bit of v, where the
  // scan begins at low+1 and wraps ascending. Iterating from the far end
  // back toward low+1 lets the last hit be the winner.
  function automatic logic [3:0] prio_pick(input logic [NUM_IR-1:0] v,
                                           input logic [2:0]        low);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      idx = low + 3'd1 + 3'(k);
      if (v[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  logic [3:0] cand_pick;
  logic [3:0] isr_pick;
  logic       cand_found;
  logic [2:0] cand_lvl;
  logic       isr_found;
  logic [2:0] isr_lvl;
  logic [2:0] cand_rank;
  logic [2:0] isr_rank;
  logic       cand_valid;
  logic       inta_fall;
  logic       inta_rise;
  logic       eoi_hit;
  logic [2:0] eoi_lvl;

  assign cand_pick  = prio_pick(irr_q & ~imr, lowest_q);
  assign isr_pick   = prio_pick(isr_q, lowest_q);
  assign cand_found = cand_pick[3];
  assign cand_lvl   = cand_pick[2:0];
  assign isr_found  = isr_pick[3];
  assign isr_lvl    = isr_pick[2:0];

  // Rank 0 is the highest priority (the level just after lowest_q).
  assign cand_rank  = cand_lvl - lowest_q - 3'd1;
  assign isr_rank   = isr_lvl - lowest_q - 3'd1;

  // Fully nested: only a strictly higher priority request may interrupt
  // the level currently in service.
  assign cand_valid = cand_found && (!isr_found || (cand_rank < isr_rank));

  assign inta_fall  = inta_prev_q & ~inta_n;
  assign inta_rise  = ~inta_prev_q & inta_n;

  always_comb begin
    state_d        = state_q;
    isr_d          = isr_q;
    lowest_d       = lowest_q;
    winner_d       = winner_q;
    spurious_d     = spurious_q;
    vector_valid_d = vector_valid_q;
    vector_out_d   = vector_out_q;
    ir_prev_d      = ir_in;
    inta_prev_d    = inta_n;
    eoi_hit        = 1'b0;
    eoi_lvl        = 3'd0;

    // Level mode tracks the pins; edge mode latches a rising edge and
    // drops the request once the pin goes low again.
    if (ltim) begin
      irr_d = ir_in;
    end else begin
      irr_d = (irr_q | (ir_in & ~ir_prev_q)) & ir_in;
    end

    // EOI is evaluated on the pre-update ISR, before any acknowledge or
    // AEOI effects so those later assignments take precedence.
    if (eoi_valid) begin
      if (eoi_specific) begin
        eoi_hit = isr_q[eoi_level];
        eoi_lvl = eoi_level;
      end else begin
        eoi_hit = isr_found;
        eoi_lvl = isr_lvl;
      end
      if (eoi_hit) begin
        isr_d[eoi_lvl] = 1'b0;
        if (eoi_rotate) begin
          lowest_d = eoi_lvl;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (inta_fall) begin
          state_d = S_ACK1;
          if (cand_valid) begin
            winner_d        = cand_lvl;
            spurious_d      = 1'b0;
            isr_d[cand_lvl] = 1'b1;
            irr_d[cand_lvl] = 1'b0;
          end else begin
            winner_d   = 3'd7;
            spurious_d = 1'b1;
          end
        end
      end

      S_ACK1: begin
        if (inta_rise) begin
          state_d = S_ACK1_HI;
        end
      end

      S_ACK1_HI: begin
        if (inta_fall) begin
          state_d        = S_ACK2;
          vector_valid_d = 1'b1;
          vector_out_d   = {vector_base, winner_q};
        end
      end

      S_ACK2: begin
        if (inta_rise) begin
          state_d        = S_IDLE;
          vector_valid_d = 1'b0;
          if (aeoi && !spurious_q) begin
            isr_d[winner_q] = 1'b0;
            if (rotate_aeoi) begin
              lowest_d = winner_q;
            end
          end
        end else begin
          vector_out_d = {vector_base, winner_q};
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // INT drops in the same update that accepts the first INTA pulse.
    int_out_d = (state_q == S_IDLE) && !inta_fall && cand_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      irr_q          <= '0;
      isr_q          <= '0;
      ir_prev_q      <= '0;
      inta_prev_q    <= 1'b1;
      lowest_q       <= RESET_LOWEST;
      winner_q       <= 3'd0;
      spurious_q     <= 1'b0;
      int_out_q      <= 1'b0;
      vector_valid_q <= 1'b0;
      vector_out_q   <= 8'd0;
    end else begin
      state_q        <= state_d;
      irr_q          <= irr_d;
      isr_q          <= isr_d;
      ir_prev_q      <= ir_prev_d;
      inta_prev_q    <= inta_prev_d;
      lowest_q       <= lowest_d;
      winner_q       <= winner_d;
      spurious_q     <= spurious_d;
      int_out_q      <= int_out_d;
      vector_valid_q <= vector_valid_d;
      vector_out_q   <= vector_out_d;
    end
  end

  assign int_out      = int_out_q;
  assign vector_valid = vector_valid_q;
  assign vector_out   = vector_out_q;
  assign irr          = irr_q;
  assign isr          = isr_q;

endmodule
